// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: instruction-sequencing FSM (fetch/execute, multi-word ops, HALT, illegal opcodes).
// Define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT instead of executing them as NOP.
module cpu_ctrl_seq #(
    parameter int OPCODE_W = 4,
    parameter int EXT_W    = 2,
    parameter int ALU_OT_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [EXT_W-1:0]    ext_len,
    input  logic                ins_valid,
    output logic [ALU_OT_W-1:0] alu_ot,
    output logic                ins_load,
    output logic                op1_load,
    output logic                op2_load,
    output logic                pc_load,
    output logic                pc_inc,
    output logic                reg_load,
    output logic                halted,
    output logic                illegal
);
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, XFETCH, XEXEC, HALT} state_t;
    state_t state;
    logic [OPCODE_W-1:0] op_q;
    logic [EXT_W-1:0] cnt;
    logic [3:0] lo;
    logic hi, bad, is_arith, is_logic, is_multi, is_halt, last, illegal_q;
    assign lo = op_q[3:0];
    assign hi = (op_q >> 4) != '0;
    assign bad = hi || lo == 4'hf;
    assign is_arith = !hi && lo <= 4'd3;
    assign is_logic = !hi && (lo inside {4'd4, 4'd5, 4'd6, 4'd9, 4'd10});
    assign is_multi = !hi && (lo == 4'hc || lo == 4'hd);
    assign is_halt = !hi && lo == 4'he;
    assign last = cnt == EXT_W'(1);
    assign halted = state == HALT;
    assign illegal = illegal_q;
    // Strobes are gated by en so an abandoned instruction never issues a write.
    always_comb begin
        alu_ot = '0;
        ins_load = 1'b0;
        op1_load = 1'b0;
        op2_load = 1'b0;
        pc_load = 1'b0;
        pc_inc = 1'b0;
        reg_load = 1'b0;
        if (en) begin
            case (state)
                FETCH, XFETCH: begin
                    pc_load = 1'b1;
                    ins_load = ins_valid;
                end
                EXEC: begin
                    alu_ot = is_arith ? ALU_OT_W'(1) :
                             (is_logic || (!hi && (lo == 4'd7 || lo == 4'd8))) ? ALU_OT_W'(2) : '0;
                    op1_load = is_arith || is_logic || (!hi && (lo == 4'd7 || lo == 4'hc));
                    op2_load = is_arith || is_logic || (!hi && (lo == 4'd8 || lo == 4'hb));
                    reg_load = is_arith || is_logic || (!hi && (lo inside {4'd7, 4'd8, 4'hb}));
                    pc_inc = !is_halt && !(bad && TRAP);
                end
                XEXEC: begin
                    pc_inc = 1'b1;
                    reg_load = last;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_q <= '0;
            cnt <= '0;
            illegal_q <= 1'b0;
        end else if (!en) begin
            state <= IDLE;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: if (ins_valid) begin
                    op_q <= opcode;
                    cnt <= (ext_len == '0) ? EXT_W'(1) : ext_len;
                    state <= EXEC;
                end
                EXEC: if (bad && TRAP) begin
                    illegal_q <= 1'b1;
                    state <= HALT;
                end else begin
                    state <= is_halt ? HALT : is_multi ? XFETCH : FETCH;
                end
                XFETCH: if (ins_valid) state <= XEXEC;
                XEXEC: begin
                    cnt <= cnt - 1'b1;
                    state <= last ? FETCH : XFETCH;
                end
                default: state <= state;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb_cpu_ctrl_seq: instruction-level scoreboard bench for cpu_ctrl_seq (OPCODE_W=5 to reach high-bit illegal opcodes).
module tb_cpu_ctrl_seq;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, ins_valid = 1'b0;
    logic [4:0] opcode = '0;
    logic [1:0] ext_len = '0;
    logic [1:0] alu_ot;
    logic ins_load, op1_load, op2_load, pc_load, pc_inc, reg_load, halted, illegal;
    logic [9:0] act;
    logic [9:0] q_exp[$];
    int total = 0, bad = 0;
    bit ill_s = 1'b0;

    cpu_ctrl_seq #(.OPCODE_W(5), .EXT_W(2), .ALU_OT_W(2)) dut (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .ext_len(ext_len), .ins_valid(ins_valid),
        .alu_ot(alu_ot), .ins_load(ins_load), .op1_load(op1_load), .op2_load(op2_load),
        .pc_load(pc_load), .pc_inc(pc_inc), .reg_load(reg_load), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;
    assign act = {alu_ot, ins_load, op1_load, op2_load, pc_load, pc_inc, reg_load, halted, illegal};

    function automatic logic [9:0] mk(input logic [1:0] a, input bit il, o1, o2, pl, pi, rl, h, ill);
        return {a, il, o1, o2, pl, pi, rl, h, ill};
    endfunction
    function automatic logic [9:0] fx(input bit v);
        return mk(2'd0, v, 0, 0, 1, 0, 0, 0, 0);
    endfunction
    function automatic bit is_ill(input logic [4:0] op);
        return op[4] || op[3:0] == 4'hf;
    endfunction
    function automatic logic [4:0] rop();
        return 5'($urandom);
    endfunction
    // Expected EXEC-cycle strobes straight from the opcode table.
    function automatic logic [9:0] exec_exp(input logic [4:0] op);
        if (is_ill(op)) return TRAP ? '0 : mk(2'd0, 0, 0, 0, 0, 1, 0, 0, 0);
        case (op[3:0])
            4'd0, 4'd1, 4'd2, 4'd3:          return mk(2'd1, 0, 1, 1, 0, 1, 1, 0, 0);
            4'd4, 4'd5, 4'd6, 4'd9, 4'd10:   return mk(2'd2, 0, 1, 1, 0, 1, 1, 0, 0);
            4'd7:                            return mk(2'd2, 0, 1, 0, 0, 1, 1, 0, 0);
            4'd8:                            return mk(2'd2, 0, 0, 1, 0, 1, 1, 0, 0);
            4'd11:                           return mk(2'd0, 0, 0, 1, 0, 1, 1, 0, 0);
            4'd12:                           return mk(2'd0, 0, 1, 0, 0, 1, 0, 0, 0);
            4'd13:                           return mk(2'd0, 0, 0, 0, 0, 1, 0, 0, 0);
            default:                         return '0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [9:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit e, input bit v, input logic [4:0] op, input logic [1:0] ext, input logic [9:0] x);
        en = e;
        ins_valid = v;
        opcode = op;
        ext_len = ext;
        q_exp.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit ab_ok, input bit v, input logic [4:0] op, input logic [1:0] ext,
                       input logic [9:0] x, output bit ab);
        ab = ab_ok && $urandom_range(0, 29) == 0;
        if (ab) begin
            drive(0, v, op, ext, '0);
            drive(1, 1'($urandom), rop(), 2'($urandom), '0);
        end else begin
            drive(1, v, op, ext, x);
        end
    endtask

    task automatic instr(input logic [4:0] op, input logic [1:0] ext, input int st, input bit ab_ok);
        bit ab;
        int n;
        for (int i = 0; i <= st; i++) begin
            cyc(ab_ok, i == st, (i == st) ? op : rop(), (i == st) ? ext : 2'($urandom), fx(i == st), ab);
            if (ab) return;
        end
        cyc(ab_ok, 1'($urandom), rop(), 2'($urandom), exec_exp(op), ab);
        if (ab) return;
        if ((!op[4] && op[3:0] == 4'he) || (TRAP && is_ill(op))) begin
            ill_s = TRAP && is_ill(op);
            repeat ($urandom_range(1, 3)) drive(1, 1'($urandom), rop(), 2'($urandom), mk(2'd0, 0, 0, 0, 0, 0, 0, 1, ill_s));
            drive(0, 1'($urandom), rop(), 2'($urandom), mk(2'd0, 0, 0, 0, 0, 0, 0, 1, ill_s));
            ill_s = 1'b0;
            drive(1, 1'($urandom), rop(), 2'($urandom), '0);
            return;
        end
        if (!op[4] && (op[3:0] == 4'hc || op[3:0] == 4'hd)) begin
            n = (ext == 2'd0) ? 1 : int'(ext);
            for (int k = 1; k <= n; k++) begin
                for (int i = 0; i <= st; i++) begin
                    cyc(ab_ok, i == st, rop(), 2'($urandom), fx(i == st), ab);
                    if (ab) return;
                end
                cyc(ab_ok, 1'($urandom), rop(), 2'($urandom), mk(2'd0, 0, 0, 0, 0, 1, k == n, 0, 0), ab);
                if (ab) return;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) check("cycle", q_exp.pop_front());
        end
    end

    initial begin
        #1 check("reset_outputs", '0);
        @(posedge clk);
        #1 check("reset_hold", '0);
        rst = 1'b0;
        drive(1, 0, '0, '0, '0);
        instr(5'h00, 2'd0, 0, 0);
        instr(5'h04, 2'd3, 0, 0);
        instr(5'h0b, 2'd1, 3, 0);
        instr(5'h0c, 2'd3, 0, 0);
        instr(5'h07, 2'd0, 0, 0);
        instr(5'h08, 2'd0, 1, 0);
        instr(5'h0e, 2'd0, 0, 0);
        instr(5'h0f, 2'd2, 0, 0);
        instr(5'h13, 2'd0, 0, 0);
        instr(5'h0d, 2'd0, 0, 0);
        instr(5'h0d, 2'd2, 1, 0);
        drive(1, 1, 5'h0d, 2'd2, fx(1));
        drive(1, 0, rop(), 2'd0, exec_exp(5'h0d));
        drive(1, 1, rop(), 2'd0, fx(1));
        drive(0, 1, rop(), 2'd0, '0);
        drive(1, 0, rop(), 2'd0, '0);
        drive(1, 1, 5'h0c, 2'd3, fx(1));
        drive(1, 0, rop(), 2'd0, exec_exp(5'h0c));
        en = 1'b1;
        ins_valid = 1'b0;
        q_exp.push_back(fx(0));
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_rst", '0);
        @(posedge clk);
        #1 check("rst_held", '0);
        rst = 1'b0;
        drive(1, 0, '0, '0, '0);
        drive(1, 0, rop(), 2'd0, fx(0));
        repeat (200) instr(($urandom_range(0, 7) == 0) ? rop() : {1'b0, 4'($urandom)},
                           2'($urandom), $urandom_range(0, 2), 1);
        @(negedge clk);
        #1;
        if (q_exp.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", q_exp.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
